uart_rx_shift: RTL and testbench

UART_RX_SHIFT -- requirements
Module: uart_rx_shift

---
 rtl/uart_rx_shift.sv | 146 ++++++++++++++
 tb/tb_uart_rx_shift.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_shift.sv
// Oversampling UART receiver: 8N1 framing, LSB first, mid-bit sampling driven by an external tick.
// Reports good frames via a one-cycle valid pulse and bad stop bits via a one-cycle frame_err pulse.
`timescale 1ns/1ps
module uart_rx_shift #(
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          os_cnt_q, os_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchronizer runs every clk; idle-high reset value avoids a false start after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    os_cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (os_cnt_q == HALF_M1) begin
                        os_cnt_d  = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == FULL_M1) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        os_cnt_d  = '0;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (os_cnt_q == FULL_M1) begin
                        os_cnt_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    os_cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    os_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_shift.sv
// Self-checking bench for uart_rx_shift: directed scenarios plus randomized frames,
// compared every cycle against a sample-schedule model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_shift;

    localparam int unsigned OVS  = 16;
    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx_shift #(.OVS(OVS), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Tick generator: one-clk pulse every tick_period clocks while enabled.
    int unsigned tick_period = 4;
    bit          tick_en     = 1'b1;
    initial begin
        int unsigned c;
        c    = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            c    = (c + 1 >= tick_period) ? 0 : c + 1;
            tick = tick_en && (c == 0);
        end
    end

    // Reference model: line value seen SYNC clocks late; once a start is seen at tick t0,
    // samples fall at t0+OVS/2 (start), t0+OVS/2+k*OVS for data bits k=1..8 and stop k=9.
    int unsigned      tb_ticks = 0;
    int               m_mode   = 0;   // 0 idle, 1 in frame, 2 break
    int unsigned      m_n      = 0;
    int unsigned      m_t0     = 0;
    logic [7:0]       m_bits   = '0;
    logic [SYNC-1:0]  m_hist   = '1;
    logic [7:0]       e_data   = '0;
    logic             e_valid  = 1'b0;
    logic             e_ferr   = 1'b0;
    logic             e_busy   = 1'b0;

    always @(posedge clk) begin
        logic rs;
        int   rel;
        int   k;
        if (tick) tb_ticks++;
        rs      = m_hist[SYNC-1];
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        if (rst) begin
            m_mode = 0;
            e_data = '0;
            m_hist = '1;
        end else begin
            if (tick) begin
                case (m_mode)
                    0: if (!rs) begin m_mode = 1; m_t0 = m_n; end
                    1: begin
                        rel = int'(m_n - m_t0);
                        if (rel == OVS / 2) begin
                            if (rs) m_mode = 0;
                        end else if (rel > OVS / 2 && (rel - OVS / 2) % OVS == 0) begin
                            k = (rel - OVS / 2) / OVS;
                            if (k <= 8) m_bits[k-1] = rs;
                            else if (rs) begin e_data = m_bits; e_valid = 1'b1; m_mode = 0; end
                            else begin e_ferr = 1'b1; m_mode = 2; end
                        end
                    end
                    default: if (rs) m_mode = 0;
                endcase
                m_n++;
            end
            m_hist = {m_hist[SYNC-2:0], rx};
        end
        e_busy = (m_mode != 0);
    end

    // Per-cycle comparison against the model, plus pulse bookkeeping for scenario checks.
    bit          cmp_en = 1'b0;
    int unsigned v_cnt  = 0;
    int unsigned f_cnt  = 0;
    int unsigned b_cnt  = 0;
    logic [7:0]  got_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            check("data",      32'(data),      32'(e_data));
            check("valid",     32'(valid),     32'(e_valid));
            check("frame_err", 32'(frame_err), 32'(e_ferr));
            check("busy",      32'(busy),      32'(e_busy));
            if (valid) begin v_cnt++; got_q.push_back(data); end
            if (frame_err) f_cnt++;
            if (busy) b_cnt++;
        end
    end

    task automatic clear_counts();
        v_cnt = 0;
        f_cnt = 0;
        b_cnt = 0;
        got_q.delete();
    endtask

    task automatic wait_ticks(input int unsigned nt);
        int unsigned target;
        int unsigned guard;
        target = tb_ticks + nt;
        guard  = 0;
        while (tb_ticks < target) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                n_checks++;
                $display("FAIL wait_ticks: got %0d ticks required %0d", tb_ticks, target);
                return;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopbit);
        rx = 1'b0;
        wait_ticks(OVS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(OVS);
        end
        rx = stopbit;
        wait_ticks(OVS);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d0;
        logic [7:0]  rb;
        bit          bad;
        int unsigned exp_v;
        int unsigned exp_f;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_data",  32'(data),      32'h00);
        check("rst_valid", 32'(valid),     32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        rst = 1'b0;

        // Single good frame
        wait_ticks(4);
        clear_counts();
        send_byte(8'hA5, 1'b1);
        wait_ticks(2 * OVS);
        check("a5_data",       32'(data),   32'hA5);
        check("a5_model_data", 32'(e_data), 32'hA5);
        check("a5_valid_clks", v_cnt,       1);
        check("a5_ferr",       f_cnt,       0);
        check("a5_busy",       32'(busy),   32'h0);

        // Start-bit glitch
        clear_counts();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(OVS);
        check("glitch_busy_seen", 32'(b_cnt != 0), 32'h1);
        check("glitch_busy_end",  32'(busy),       32'h0);
        check("glitch_valid",     v_cnt,           0);
        check("glitch_ferr",      f_cnt,           0);

        // Good frame, then bad stop bit with line held low
        clear_counts();
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b0);
        wait_ticks(40);
        check("brk_ferr",      f_cnt,     1);
        check("brk_valid",     v_cnt,     1);
        check("brk_data",      32'(data), 32'h3C);
        check("brk_busy_low",  32'(busy), 32'h1);
        rx = 1'b1;
        wait_ticks(8);
        check("brk_busy_rel",  32'(busy), 32'h0);
        check("brk_ferr_once", f_cnt,     1);

        // Reset in the middle of a frame
        clear_counts();
        rx = 1'b0;
        wait_ticks(OVS);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            wait_ticks(OVS);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_data",  32'(data),      32'h00);
        check("mrst_busy",  32'(busy),      32'h0);
        check("mrst_valid", 32'(valid),     32'h0);
        check("mrst_ferr",  32'(frame_err), 32'h0);
        wait_ticks(4);
        send_byte(8'h81, 1'b1);
        wait_ticks(2 * OVS);
        check("mrst_81_data",  32'(data), 32'h81);
        check("mrst_81_valid", v_cnt,     1);
        check("mrst_81_ferr",  f_cnt,     0);

        // Back-to-back frames with no idle gap
        clear_counts();
        wait_ticks(4);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_ticks(2 * OVS);
        check("b2b_valid", v_cnt, 2);
        check("b2b_ferr",  f_cnt, 0);
        check("b2b_first",  32'((got_q.size() > 0) ? got_q[0] : 8'hXX), 32'h00);
        check("b2b_second", 32'((got_q.size() > 1) ? got_q[1] : 8'hXX), 32'hFF);

        // Tick stall mid-frame
        clear_counts();
        wait_ticks(4);
        fork
            send_byte(8'h96, 1'b1);
            begin
                wait_ticks(4 * OVS);
                tick_en = 1'b0;
                @(negedge clk);
                d0 = data;
                repeat (100) @(negedge clk);
                check("hold_data",  32'(data), 32'(d0));
                check("hold_busy",  32'(busy), 32'h1);
                check("hold_valid", v_cnt,     0);
                tick_en = 1'b1;
            end
        join
        wait_ticks(2 * OVS);
        check("hold_96_data",  32'(data), 32'h96);
        check("hold_96_valid", v_cnt,     1);
        check("hold_96_ferr",  f_cnt,     0);

        // Randomized frames, tick rates and stop-bit errors
        clear_counts();
        exp_v = 0;
        exp_f = 0;
        for (int f = 0; f < 30; f++) begin
            tick_period = $urandom_range(1, 4);
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_byte(rb, !bad);
            rx = 1'b1;
            if (bad) exp_f++;
            else exp_v++;
            wait_ticks(bad ? $urandom_range(6, 12) : $urandom_range(0, 12));
        end
        wait_ticks(2 * OVS);
        check("rand_valid_cnt", v_cnt, exp_v);
        check("rand_ferr_cnt",  f_cnt, exp_f);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
